lcd_timing_driver: RTL and testbench

//  Video timing master for the 800x480 RGB LCD panel. Free-running h/v counters generate
//  lcd_hs, lcd_vs and lcd_de, and issue pixel_xpos/pixel_ypos one cycle ahead of lcd_de.
//  The pixel generator (7-seg digit renderer) returns registered pixel_data one cycle later.

---
 rtl/lcd_timing_driver_if.sv | 47 ++++
 rtl/lcd_timing_driver.sv | 132 +++++++++++++
 tb/tb_lcd_timing_driver.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_driver_if.sv
// Pixel-request and panel-side signal bundle for the LCD timing driver.
//   master : timing driver (drives coordinates, syncs, data enable, rgb, frame strobe)
//   slave  : pixel generator / panel view (drives pixel_data)
// Signals:
//   pixel_data   24  RGB888 returned by the pixel generator, registered from last cycle's coords
//   pixel_xpos   11  requested column (0 outside the request window)
//   pixel_ypos   11  requested row (0 outside the request window)
//   lcd_hs       1   horizontal sync
//   lcd_vs       1   vertical sync
//   lcd_de       1   data enable
//   lcd_rgb      24  panel pixel data
//   frame_start  1   one-cycle pulse at the first position of each frame
interface lcd_timing_driver_if;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 24;

  logic [RGB_W-1:0]   pixel_data;
  logic [COORD_W-1:0] pixel_xpos;
  logic [COORD_W-1:0] pixel_ypos;
  logic               lcd_hs;
  logic               lcd_vs;
  logic               lcd_de;
  logic [RGB_W-1:0]   lcd_rgb;
  logic               frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos,
    output pixel_ypos,
    output lcd_hs,
    output lcd_vs,
    output lcd_de,
    output lcd_rgb,
    output frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos,
    input  pixel_ypos,
    input  lcd_hs,
    input  lcd_vs,
    input  lcd_de,
    input  lcd_rgb,
    input  frame_start
  );
endinterface

// File: rtl/lcd_timing_driver.sv
// Video timing master for an RGB LCD panel (default 800x480, 1056x525 total).
// Free-running h/v counters produce registered sync, data-enable, frame strobe and pixel
// request coordinates; coordinates lead lcd_de by one clock so the pixel generator's
// registered pixel_data lines up with the active window.
// Ports:
//   lcd_clk    in  pixel clock
//   sys_rst_n  in  asynchronous active-low reset
//   bus        lcd_timing_driver_if.master (pixel_data in; coords, syncs, de, rgb, frame_start out)
module lcd_timing_driver #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_DISP   = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                lcd_clk,
  input  logic                sys_rst_n,
  lcd_timing_driver_if.master bus
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HA0     = H_SYNC + H_BACK;
  localparam int unsigned VA0     = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(HA0);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(HA0 + H_DISP);
  localparam logic [CNT_W-1:0] H_REQ_BEG  = CNT_W'(HA0 - 1);
  localparam logic [CNT_W-1:0] H_REQ_END  = CNT_W'(HA0 + H_DISP - 1);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(VA0);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(VA0 + V_DISP);

  // Counters hold the position whose outputs are registered on the next edge.
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  logic             hs_d;
  logic             vs_d;
  logic             de_d;
  logic             fs_d;
  logic             line_act;
  logic             req_d;
  logic [CNT_W-1:0] xpos_d;
  logic [CNT_W-1:0] ypos_d;

  logic             hs_q;
  logic             vs_q;
  logic             de_q;
  logic             fs_q;
  logic [CNT_W-1:0] xpos_q;
  logic [CNT_W-1:0] ypos_q;

  // Counter advance: h every clock, v on h wrap.
  always_comb begin
    h_nxt = h_cnt + CNT_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Output decode for the current position; the request window leads de by one column.
  always_comb begin
    hs_d     = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_d     = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    line_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    de_d     = line_act && (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
    req_d    = line_act && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
    fs_d     = (h_cnt == '0) && (v_cnt == '0);
    xpos_d   = '0;
    ypos_d   = '0;
    if (req_d) begin
      xpos_d = h_cnt - H_REQ_BEG;
      ypos_d = v_cnt - V_ACT_BEG;
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  assign bus.lcd_hs      = hs_q;
  assign bus.lcd_vs      = vs_q;
  assign bus.lcd_de      = de_q;
  assign bus.frame_start = fs_q;
  assign bus.pixel_xpos  = xpos_q;
  assign bus.pixel_ypos  = ypos_q;

  // Panel data is blanked outside the active window; pixel_data is already one cycle late.
  assign bus.lcd_rgb = de_q ? bus.pixel_data : '0;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver: a full-size instance checks real line/frame numbers
// over the first 37 lines, a reduced-timing instance checks frame period and mid-frame reset.
module tb_lcd_timing_driver;

  localparam int unsigned S_HS = 4, S_HB = 3, S_HD = 8, S_HF = 2;
  localparam int unsigned S_VS = 2, S_VB = 3, S_VD = 4, S_VF = 2;
  localparam int unsigned S_HT = S_HS + S_HB + S_HD + S_HF;   // 17
  localparam int unsigned S_FRAME = S_HT * (S_VS + S_VB + S_VD + S_VF); // 187
  localparam int unsigned F_LIMIT = 37 * 1056;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;

  logic lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  logic rst_full_n;
  logic rst_small_n;
  logic force_full;
  logic force_small;

  lcd_timing_driver_if bus_full ();
  lcd_timing_driver_if bus_small ();

  lcd_timing_driver dut_full (
    .lcd_clk  (lcd_clk),
    .sys_rst_n(rst_full_n),
    .bus      (bus_full)
  );

  lcd_timing_driver #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
    .SYNC_POL(1'b0)
  ) dut_small (
    .lcd_clk  (lcd_clk),
    .sys_rst_n(rst_small_n),
    .bus      (bus_small)
  );

  // Pixel generator models: echo registered xpos, or all-ones when forced.
  always_ff @(posedge lcd_clk) begin
    bus_full.pixel_data  <= force_full  ? 24'hFFFFFF : {13'h0, bus_full.pixel_xpos};
    bus_small.pixel_data <= force_small ? 24'hFFFFFF : {13'h0, bus_small.pixel_xpos};
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned mm_hs, mm_vs, mm_de, mm_fs, mm_pos, mm_rgb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mm();
    mm_hs = 0; mm_vs = 0; mm_de = 0; mm_fs = 0; mm_pos = 0; mm_rgb = 0;
  endtask

  // Expected outputs at output-aligned position index p (p=0 is the first edge after reset).
  function automatic exp_t expect_at(input int unsigned hsy, hbp, hdi, hfp,
                                     input int unsigned vsy, vbp, vdi, vfp,
                                     input int unsigned p);
    exp_t e;
    int unsigned ht, vt, h, v, ha0, va0;
    logic act;
    ht  = hsy + hbp + hdi + hfp;
    vt  = vsy + vbp + vdi + vfp;
    h   = p % ht;
    v   = (p / ht) % vt;
    ha0 = hsy + hbp;
    va0 = vsy + vbp;
    act = (v >= va0) && (v < va0 + vdi);
    e.hs  = (h < hsy) ? 1'b0 : 1'b1;
    e.vs  = (v < vsy) ? 1'b0 : 1'b1;
    e.de  = act && (h >= ha0) && (h < ha0 + hdi);
    e.fs  = (h == 0) && (v == 0);
    e.req = act && (h + 1 >= ha0) && (h + 1 < ha0 + hdi);
    e.x   = e.req ? 11'(h + 1 - ha0) : 11'd0;
    e.y   = e.req ? 11'(v - va0) : 11'd0;
    return e;
  endfunction

  task automatic score(input exp_t e, input logic pf, input logic [10:0] px,
                       input logic hs, input logic vs, input logic de, input logic fs,
                       input logic [10:0] x, input logic [10:0] y, input logic [23:0] rgb);
    logic [23:0] rgb_e;
    rgb_e = e.de ? (pf ? 24'hFFFFFF : {13'h0, px}) : 24'h0;
    if (hs !== e.hs) mm_hs++;
    if (vs !== e.vs) mm_vs++;
    if (de !== e.de) mm_de++;
    if (fs !== e.fs) mm_fs++;
    if ((x !== e.x) || (y !== e.y)) mm_pos++;
    if (rgb !== rgb_e) mm_rgb++;
  endtask

  task automatic chk_reset_small(input string tag);
    chk({tag, "_hs"},  32'(bus_small.lcd_hs), 32'd1);
    chk({tag, "_vs"},  32'(bus_small.lcd_vs), 32'd1);
    chk({tag, "_de"},  32'(bus_small.lcd_de), 32'd0);
    chk({tag, "_fs"},  32'(bus_small.frame_start), 32'd0);
    chk({tag, "_xy"},  32'({bus_small.pixel_xpos, bus_small.pixel_ypos}), 32'd0);
    chk({tag, "_rgb"}, 32'(bus_small.lcd_rgb), 32'd0);
  endtask

  task automatic report_mm(input string tag);
    chk({tag, "_hs_mismatches"},  mm_hs,  32'd0);
    chk({tag, "_vs_mismatches"},  mm_vs,  32'd0);
    chk({tag, "_de_mismatches"},  mm_de,  32'd0);
    chk({tag, "_fs_mismatches"},  mm_fs,  32'd0);
    chk({tag, "_pos_mismatches"}, mm_pos, 32'd0);
    chk({tag, "_rgb_mismatches"}, mm_rgb, 32'd0);
  endtask

  initial begin
    exp_t        e;
    logic        prev_force;
    logic [10:0] prev_x;
    int unsigned fs_second, de_frame0;
    int unsigned h, v;
    int unsigned hs_low0, vs_low, first_de, last_fall, de_cnt35, de_lines;
    logic        found_de, prev_hs, line_had_de;
    logic [10:0] prev_obs_x, prev_obs_y, x_first, y_first, x_last;

    rst_full_n  = 1'b0;
    rst_small_n = 1'b0;
    force_full  = 1'b1;
    force_small = 1'b1;
    repeat (3) @(posedge lcd_clk);
    #1;

    // Reset state, pixel_data forced to all-ones so rgb blanking is visible.
    chk_reset_small("small_reset");
    chk("full_reset_hs",  32'(bus_full.lcd_hs), 32'd1);
    chk("full_reset_vs",  32'(bus_full.lcd_vs), 32'd1);
    chk("full_reset_de",  32'(bus_full.lcd_de), 32'd0);
    chk("full_reset_fs",  32'(bus_full.frame_start), 32'd0);
    chk("full_reset_rgb", 32'(bus_full.lcd_rgb), 32'd0);

    // ---------------- reduced-timing instance ----------------
    @(negedge lcd_clk);
    rst_small_n = 1'b1;
    @(posedge lcd_clk);
    #1;
    chk("small_first_fs", 32'(bus_small.frame_start), 32'd1);
    chk("small_first_hs", 32'(bus_small.lcd_hs), 32'd0);
    chk("small_first_vs", 32'(bus_small.lcd_vs), 32'd0);
    chk("small_first_de", 32'(bus_small.lcd_de), 32'd0);

    clear_mm();
    prev_force = 1'b1;
    prev_x     = '0;
    fs_second  = 0;
    de_frame0  = 0;
    // Run to line 7, column 10 of the third frame (inside the active window).
    for (int unsigned p = 0; p < 2 * S_FRAME + 7 * S_HT + 10; p++) begin
      e = expect_at(S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, p);
      score(e, prev_force, prev_x, bus_small.lcd_hs, bus_small.lcd_vs, bus_small.lcd_de,
            bus_small.frame_start, bus_small.pixel_xpos, bus_small.pixel_ypos, bus_small.lcd_rgb);
      if (bus_small.frame_start && p != 0 && fs_second == 0) fs_second = p;
      if (p < S_FRAME && bus_small.lcd_de) de_frame0++;
      force_small = ((p / S_HT) % 2) == 1;
      prev_force  = force_small;
      prev_x      = e.x;
      @(posedge lcd_clk);
      #1;
    end
    report_mm("small_run");
    chk("small_frame_period", fs_second, S_FRAME);
    chk("small_de_per_frame", de_frame0, S_HD * S_VD);
    chk("small_pre_reset_de", 32'(bus_small.lcd_de), 32'd1);

    // Mid-frame asynchronous reset between edges.
    force_small = 1'b1;
    #2;
    rst_small_n = 1'b0;
    #1;
    chk_reset_small("small_async_reset");
    repeat (3) @(posedge lcd_clk);
    #1;
    chk_reset_small("small_held_reset");
    @(negedge lcd_clk);
    rst_small_n = 1'b1;
    @(posedge lcd_clk);
    #1;
    chk("small_restart_fs", 32'(bus_small.frame_start), 32'd1);
    chk("small_restart_hs", 32'(bus_small.lcd_hs), 32'd0);
    chk("small_restart_vs", 32'(bus_small.lcd_vs), 32'd0);

    clear_mm();
    prev_force = 1'b1;
    prev_x     = '0;
    fs_second  = 0;
    for (int unsigned p = 0; p < S_FRAME + 3; p++) begin
      e = expect_at(S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, p);
      score(e, prev_force, prev_x, bus_small.lcd_hs, bus_small.lcd_vs, bus_small.lcd_de,
            bus_small.frame_start, bus_small.pixel_xpos, bus_small.pixel_ypos, bus_small.lcd_rgb);
      if (bus_small.frame_start && p != 0 && fs_second == 0) fs_second = p;
      force_small = 1'b0;
      prev_force  = force_small;
      prev_x      = e.x;
      @(posedge lcd_clk);
      #1;
    end
    report_mm("small_after_reset");
    chk("small_restart_period", fs_second, S_FRAME);

    // ---------------- full-size instance, first 37 lines ----------------
    @(negedge lcd_clk);
    rst_full_n = 1'b1;
    @(posedge lcd_clk);
    #1;
    chk("full_first_fs", 32'(bus_full.frame_start), 32'd1);
    chk("full_first_hs", 32'(bus_full.lcd_hs), 32'd0);
    chk("full_first_vs", 32'(bus_full.lcd_vs), 32'd0);
    chk("full_first_de", 32'(bus_full.lcd_de), 32'd0);

    clear_mm();
    force_full  = 1'b0;
    prev_force  = 1'b1;
    prev_x      = '0;
    hs_low0     = 0;
    vs_low      = 0;
    first_de    = 0;
    last_fall   = 0;
    de_cnt35    = 0;
    de_lines    = 0;
    found_de    = 1'b0;
    prev_hs     = 1'b1;
    line_had_de = 1'b0;
    prev_obs_x  = '0;
    prev_obs_y  = '0;
    x_first     = '1;
    y_first     = '1;
    x_last      = '0;
    for (int unsigned p = 0; p < F_LIMIT; p++) begin
      h = p % 1056;
      v = p / 1056;
      e = expect_at(128, 88, 800, 40, 2, 33, 480, 10, p);
      score(e, prev_force, prev_x, bus_full.lcd_hs, bus_full.lcd_vs, bus_full.lcd_de,
            bus_full.frame_start, bus_full.pixel_xpos, bus_full.pixel_ypos, bus_full.lcd_rgb);
      if (v == 0 && !bus_full.lcd_hs) hs_low0++;
      if (!bus_full.lcd_vs) vs_low++;
      if (!found_de && prev_hs && !bus_full.lcd_hs) last_fall = p;
      if (!found_de && bus_full.lcd_de) begin
        found_de = 1'b1;
        first_de = p;
        x_first  = prev_obs_x;
        y_first  = prev_obs_y;
      end
      if (v == 35 && bus_full.lcd_de) de_cnt35++;
      if (v == 35 && h == 1014) x_last = bus_full.pixel_xpos;
      if (h == 0) line_had_de = 1'b0;
      if (bus_full.lcd_de) line_had_de = 1'b1;
      if (h == 1055 && line_had_de) de_lines++;
      prev_hs    = bus_full.lcd_hs;
      prev_obs_x = bus_full.pixel_xpos;
      prev_obs_y = bus_full.pixel_ypos;
      force_full = (v == 36);
      prev_force = force_full;
      prev_x     = e.x;
      @(posedge lcd_clk);
      #1;
    end
    report_mm("full_run");
    chk("full_hs_low_line0",    hs_low0, 32'd128);
    chk("full_vs_low_clks",     vs_low, 32'd2112);
    chk("full_first_de_pos",    first_de, 32'd37176);
    chk("full_de_after_hsfall", first_de - last_fall, 32'd216);
    chk("full_de_len_line35",   de_cnt35, 32'd800);
    chk("full_de_lines",        de_lines, 32'd2);
    chk("full_first_req_x",     32'(x_first), 32'd0);
    chk("full_first_req_y",     32'(y_first), 32'd0);
    chk("full_last_req_x",      32'(x_last), 32'd799);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
